// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and helpers for the packet-level UART transmit arbiter.
package uart_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } arb_state_t;

  localparam int unsigned MAX_REQ = 8;

  // Modular increment of a requester index within 0..n-1.
  function automatic logic [2:0] next_idx(input logic [2:0] last, input int unsigned n);
    if (last >= 3'(n - 1)) begin
      return 3'd0;
    end else begin
      return last + 3'd1;
    end
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Round-robin picker: first asserted request strictly after the last grant, wrapping.
module rr_pick
  import uart_arb_pkg::*;
#(
  parameter int unsigned N_REQ = 4
) (
  input  logic [N_REQ-1:0] req,
  input  logic [2:0]       last,
  output logic             found,
  output logic [2:0]       idx
);

  logic [MAX_REQ-1:0] req_ext_s;
  logic [MAX_REQ-1:0] rot_s;
  logic [2:0]         start_s;
  logic [2:0]         ptr_s;
  logic [2:0]         enc_s;

  // Rotate so the search starts after last, priority-encode, rotate the result back.
  always_comb begin
    req_ext_s              = {MAX_REQ{1'b0}};
    req_ext_s[N_REQ-1:0]   = req;
    start_s                = next_idx(last, N_REQ);
    rot_s                  = {MAX_REQ{1'b0}};
    ptr_s                  = start_s;
    for (int k = 0; k < int'(N_REQ); k++) begin
      rot_s[k] = req_ext_s[ptr_s];
      ptr_s    = next_idx(ptr_s, N_REQ);
    end
    found = |rot_s;
    enc_s = 3'd0;
    for (int k = int'(N_REQ) - 1; k >= 0; k--) begin
      if (rot_s[k]) begin
        enc_s = 3'(k);
      end else begin
        enc_s = enc_s;
      end
    end
    idx = start_s;
    for (int k = 0; k < int'(N_REQ) - 1; k++) begin
      if (3'(k) < enc_s) begin
        idx = next_idx(idx, N_REQ);
      end else begin
        idx = idx;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Grants whole tlast-delimited packets round-robin onto the single UART byte stream,
// with a watchdog that aborts an owner stalling its own tvalid mid-packet.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned GAP_MAX = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [8*N_REQ-1:0] req_tdata,
  input  logic [N_REQ-1:0]   req_tvalid,
  input  logic [N_REQ-1:0]   req_tlast,
  output logic [N_REQ-1:0]   req_tready,
  output logic [7:0]         m_tdata,
  output logic               m_tvalid,
  input  logic               m_tready,
  output logic [2:0]         grant_id,
  output logic               busy,
  output logic               abort_pulse
);

  localparam int CNT_W = $clog2(GAP_MAX + 1);

  arb_state_t       state_q, state_d;
  logic [2:0]       grant_q, grant_d;
  logic [2:0]       last_q, last_d;
  logic [CNT_W-1:0] gap_q, gap_d;
  logic             abort_q, abort_d;

  logic             pick_found_s;
  logic [2:0]       pick_idx_s;
  logic [MAX_REQ-1:0] valid_ext_s;
  logic [MAX_REQ-1:0] tlast_ext_s;
  logic [MAX_REQ-1:0] ready_ext_s;
  logic [7:0]         data_ext_s [MAX_REQ];

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req   (req_tvalid),
    .last  (last_q),
    .found (pick_found_s),
    .idx   (pick_idx_s)
  );

  // Widen requester buses to MAX_REQ so a 3-bit owner index selects cleanly.
  always_comb begin
    valid_ext_s            = {MAX_REQ{1'b0}};
    tlast_ext_s            = {MAX_REQ{1'b0}};
    valid_ext_s[N_REQ-1:0] = req_tvalid;
    tlast_ext_s[N_REQ-1:0] = req_tlast;
    for (int i = 0; i < int'(MAX_REQ); i++) begin
      data_ext_s[i] = 8'h00;
    end
    for (int i = 0; i < int'(N_REQ); i++) begin
      data_ext_s[i] = req_tdata[8*i +: 8];
    end
  end

  // Next-state, owner pass-through and gap watchdog.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    last_d      = last_q;
    gap_d       = gap_q;
    abort_d     = 1'b0;
    m_tvalid    = 1'b0;
    m_tdata     = 8'h00;
    ready_ext_s = {MAX_REQ{1'b0}};
    case (state_q)
      IDLE: begin
        gap_d = {CNT_W{1'b0}};
        if (pick_found_s) begin
          state_d = XFER;
          grant_d = pick_idx_s;
          last_d  = pick_idx_s;
        end else begin
          state_d = IDLE;
        end
      end
      XFER: begin
        m_tvalid             = valid_ext_s[grant_q];
        m_tdata              = data_ext_s[grant_q];
        ready_ext_s[grant_q] = m_tready;
        if (m_tvalid && m_tready && tlast_ext_s[grant_q]) begin
          state_d = IDLE;
          gap_d   = {CNT_W{1'b0}};
        end else if (m_tvalid) begin
          gap_d = {CNT_W{1'b0}};
        end else if (gap_q >= CNT_W'(GAP_MAX - 1)) begin
          // Owner starved the line for GAP_MAX cycles: drop its packet.
          state_d = IDLE;
          gap_d   = {CNT_W{1'b0}};
          abort_d = 1'b1;
        end else begin
          gap_d = gap_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        gap_d   = {CNT_W{1'b0}};
      end
    endcase
  end

  // State registers; last_q resets to N_REQ-1 so requester 0 wins first.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= 3'd0;
      last_q  <= 3'(N_REQ - 1);
      gap_q   <= {CNT_W{1'b0}};
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      gap_q   <= gap_d;
      abort_q <= abort_d;
    end
  end

  assign req_tready  = ready_ext_s[N_REQ-1:0];
  assign grant_id    = grant_q;
  assign busy        = (state_q == XFER);
  assign abort_pulse = abort_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: packet pass-through, round-robin order,
// back-pressure, gap abort, mid-packet reset and single-byte packets.
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] req_tdata;
  logic [3:0]  req_tvalid;
  logic [3:0]  req_tlast;
  logic [3:0]  req_tready;
  logic [7:0]  m_tdata;
  logic        m_tvalid;
  logic        m_tready;
  logic [2:0]  grant_id;
  logic        busy;
  logic        abort_pulse;

  int tests  = 0;
  int failed = 0;

  uart_tx_arbiter #(.N_REQ(4), .GAP_MAX(255)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_tdata   (req_tdata),
    .req_tvalid  (req_tvalid),
    .req_tlast   (req_tlast),
    .req_tready  (req_tready),
    .m_tdata     (m_tdata),
    .m_tvalid    (m_tvalid),
    .m_tready    (m_tready),
    .grant_id    (grant_id),
    .busy        (busy),
    .abort_pulse (abort_pulse)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    req_tdata  = 32'h0;
    req_tvalid = 4'h0;
    req_tlast  = 4'h0;
    m_tready   = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  logic [3:0] beat;
  logic [3:0] hs;
  logic       saw_abort;
  logic       saw_ready;

  task automatic drive_rr();
    for (int i = 0; i < 4; i++) begin
      req_tdata[8*i +: 8] = 8'(16 * i + int'(beat[i]));
    end
    req_tlast = beat;
  endtask

  initial begin
    // 1: reset values, then a 3-byte packet from requester 0
    do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("reset_state", {busy, grant_id, abort_pulse, m_tvalid, m_tdata, req_tready},
          {1'b0, 3'd0, 1'b0, 1'b0, 8'h00, 4'h0});
    req_tvalid = 4'b0001;
    req_tdata  = 32'h41;
    m_tready   = 1'b1;
    #1;
    check("t1_no_grant_yet", {busy, m_tvalid, req_tready}, {1'b0, 1'b0, 4'h0});
    for (int b = 0; b < 3; b++) begin
      tick();
      req_tdata = {24'h0, 8'(8'h41 + b)};
      req_tlast = (b == 2) ? 4'b0001 : 4'b0000;
      #1;
      check($sformatf("t1_byte%0d", b), {busy, grant_id, m_tvalid, m_tdata, req_tready},
            {1'b1, 3'd0, 1'b1, 8'(8'h41 + b), 4'b0001});
    end
    tick();
    req_tvalid = 4'h0;
    req_tlast  = 4'h0;
    #1;
    check("t1_done", {busy, m_tvalid, req_tready}, {1'b0, 1'b0, 4'h0});

    // 2: four requesters with back-to-back 2-byte packets
    do_reset();
    beat       = 4'h0;
    drive_rr();
    req_tvalid = 4'hF;
    m_tready   = 1'b1;
    #1;
    check("t2_idle_start", {busy, m_tvalid}, {1'b0, 1'b0});
    for (int p = 0; p < 5; p++) begin
      for (int b = 0; b < 3; b++) begin
        hs = req_tready & req_tvalid;
        tick();
        beat = beat ^ hs;
        drive_rr();
        if (b == 2) begin
          req_tvalid = (p == 4) ? 4'h0 : 4'hF;
        end else begin
          req_tvalid = 4'hF;
        end
        #1;
        if (b < 2) begin
          check($sformatf("t2_p%0d_b%0d", p, b),
                {busy, grant_id, m_tvalid, m_tdata, req_tready},
                {1'b1, 3'(p % 4), 1'b1, 8'(16 * (p % 4) + b), 4'(1 << (p % 4))});
        end else begin
          check($sformatf("t2_p%0d_bubble", p), {busy, m_tvalid, m_tdata, req_tready},
                {1'b0, 1'b0, 8'h00, 4'h0});
        end
      end
    end

    // 3: owner 2 under long UART back-pressure
    do_reset();
    req_tvalid = 4'b0100;
    req_tdata  = 32'h0020_0000;
    m_tready   = 1'b1;
    tick();
    #1;
    check("t3_grant2", {busy, grant_id, m_tdata}, {1'b1, 3'd2, 8'h20});
    tick();
    req_tdata = 32'h0021_0000;
    req_tlast = 4'b0100;
    m_tready  = 1'b0;
    saw_abort = 1'b0;
    saw_ready = 1'b0;
    for (int c = 0; c < 500; c++) begin
      tick();
      saw_abort = saw_abort | abort_pulse;
      saw_ready = saw_ready | (|req_tready);
    end
    #1;
    check("t3_hold", {saw_abort, saw_ready, busy, m_tvalid, m_tdata},
          {1'b0, 1'b0, 1'b1, 1'b1, 8'h21});
    m_tready = 1'b1;
    #1;
    check("t3_release_ready", req_tready, 4'b0100);
    tick();
    req_tvalid = 4'h0;
    req_tlast  = 4'h0;
    #1;
    check("t3_done", {busy, abort_pulse}, {1'b0, 1'b0});

    // 4: owner 1 stalls after its first byte; watchdog aborts after 255 cycles
    do_reset();
    req_tvalid = 4'b0010;
    req_tdata  = 32'h0000_3100;
    m_tready   = 1'b1;
    tick();
    #1;
    check("t4_grant1", {busy, grant_id, m_tdata}, {1'b1, 3'd1, 8'h31});
    tick();
    req_tvalid = 4'b0101;
    req_tdata  = 32'h0070_0060;
    saw_abort  = 1'b0;
    for (int c = 0; c < 254; c++) begin
      tick();
      saw_abort = saw_abort | abort_pulse;
    end
    #1;
    check("t4_before_abort", {saw_abort, busy}, {1'b0, 1'b1});
    tick();
    #1;
    check("t4_abort", {abort_pulse, busy, m_tvalid}, {1'b1, 1'b0, 1'b0});
    tick();
    #1;
    check("t4_next_grant", {abort_pulse, busy, grant_id, m_tdata}, {1'b0, 1'b1, 3'd2, 8'h70});

    // 5: reset in the middle of a 4-byte packet
    do_reset();
    req_tvalid = 4'b0001;
    req_tdata  = 32'h50;
    m_tready   = 1'b1;
    for (int b = 0; b < 3; b++) begin
      tick();
      req_tdata = {24'h0, 8'(8'h50 + b)};
      #1;
      check($sformatf("t5_byte%0d", b), {busy, m_tdata}, {1'b1, 8'(8'h50 + b)});
    end
    rst        = 1'b1;
    req_tvalid = 4'b1001;
    req_tdata  = 32'h3300_0052;
    tick();
    #1;
    check("t5_reset", {busy, m_tvalid, req_tready, abort_pulse}, {1'b0, 1'b0, 4'h0, 1'b0});
    rst       = 1'b0;
    req_tdata = 32'h3300_0060;
    tick();
    #1;
    check("t5_first_after_rst", {busy, grant_id, m_tdata}, {1'b1, 3'd0, 8'h60});

    // 6: single-byte packet from requester 3
    do_reset();
    req_tvalid = 4'b1000;
    req_tdata  = 32'h0A00_0000;
    req_tlast  = 4'b1000;
    m_tready   = 1'b1;
    #1;
    check("t6_idle", {busy, req_tready}, {1'b0, 4'h0});
    tick();
    #1;
    check("t6_xfer", {busy, grant_id, m_tvalid, m_tdata, req_tready},
          {1'b1, 3'd3, 1'b1, 8'h0A, 4'b1000});
    tick();
    req_tvalid = 4'h0;
    req_tlast  = 4'h0;
    #1;
    check("t6_one_cycle", {busy, m_tvalid, req_tready}, {1'b0, 1'b0, 4'h0});
    tick();
    #1;
    check("t6_stays_idle", {busy, req_tready}, {1'b0, 4'h0});

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
